m68k_region_decoder: RTL

- Parametrised, registered 68000 address decoder with a runtime-loadable region table; generalises the fixed per-PCB select map.
- Generates one-hot chip selects plus per-region wait-state DTACK and a bus-error timeout for unmapped accesses.
- Sits between the 68000 core and the memory/IO blocks. The per-PCB table is loaded by the top level after ROM download.

---
 rtl/m68k_region_pkg.sv | 29 ++
 rtl/region_match.sv | 31 +++
 rtl/m68k_region_decoder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/m68k_region_pkg.sv
// Shared types for the 68000 region decoder: table entry layout, FSM states
// and the default bus-error timeout.
package m68k_region_pkg;

  // Table entries are stored zero-extended to these widths so the struct can
  // serve any ADDR_W / WAIT_W the decoder is built with.
  localparam int REGION_ADDR_MAX_W = 32;
  localparam int REGION_WAIT_MAX_W = 16;
  localparam int DEFAULT_TIMEOUT   = 64;

  typedef struct packed {
    logic [REGION_ADDR_MAX_W-1:0] start_addr;
    logic [REGION_ADDR_MAX_W-1:0] end_addr;
    logic [REGION_WAIT_MAX_W-1:0] wait_cyc;
    logic                         rd_en;
    logic                         wr_en;
    logic                         valid;
  } region_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WAIT,
    ST_ACK,
    ST_MISS,
    ST_BERR
  } state_t;

endpackage

// File: rtl/region_match.sv
// Combinational compare of an address against every table entry, with a
// lowest-index-wins priority encoder.
module region_match
  import m68k_region_pkg::*;
#(
  parameter int NUM_REGIONS = 16,
  parameter int IDX_W       = $clog2(NUM_REGIONS)
) (
  input  region_t                      regions [NUM_REGIONS],
  input  logic [REGION_ADDR_MAX_W-1:0] addr,
  input  logic                         rw,
  output logic                         hit,
  output logic [IDX_W-1:0]             idx
);

  // Scan from the top down so the lowest matching index is the final winner.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (regions[i].valid &&
          (addr >= regions[i].start_addr) &&
          (addr <= regions[i].end_addr) &&
          (rw ? regions[i].rd_en : regions[i].wr_en)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/m68k_region_decoder.sv
// Registered 68000 address decoder with a runtime-loadable region table.
// Produces one-hot chip selects, per-region wait-state DTACK and a bus-error
// timeout for accesses that hit no region.
module m68k_region_decoder
  import m68k_region_pkg::*;
#(
  parameter int NUM_REGIONS = 16,
  parameter int ADDR_W      = 24,
  parameter int WAIT_W      = 4,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cfg_we,
  input  logic [$clog2(NUM_REGIONS)-1:0] cfg_idx,
  input  logic [ADDR_W-1:0]              cfg_start,
  input  logic [ADDR_W-1:0]              cfg_end,
  input  logic [WAIT_W-1:0]              cfg_wait,
  input  logic                           cfg_rd_en,
  input  logic                           cfg_wr_en,
  input  logic                           cfg_valid,
  input  logic [ADDR_W-1:0]              cpu_a,
  input  logic                           cpu_as_n,
  input  logic                           cpu_rw,
  input  logic                           ext_wait,
  output logic [NUM_REGIONS-1:0]         cs,
  output logic [$clog2(NUM_REGIONS)-1:0] hit_idx,
  output logic                           dtack_n,
  output logic                           berr_n,
  output logic                           unmapped
);

  localparam int IDX_W = $clog2(NUM_REGIONS);
  localparam int TO_W  = $clog2(TIMEOUT);
  localparam int CNT_W = (TO_W > WAIT_W) ? TO_W : WAIT_W;

  logic [ADDR_W-1:0]      start_q [NUM_REGIONS];
  logic [ADDR_W-1:0]      end_q   [NUM_REGIONS];
  logic [WAIT_W-1:0]      wait_q  [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] valid_q;
  logic [NUM_REGIONS-1:0] rd_en_q;
  logic [NUM_REGIONS-1:0] wr_en_q;
  region_t                regions [NUM_REGIONS];

  logic                   cfg_idx_ok;
  logic                   match_hit;
  logic [IDX_W-1:0]       match_idx;
  logic [WAIT_W-1:0]      match_wait;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;

  assign cfg_idx_ok = (32'(cfg_idx) < NUM_REGIONS);
  assign match_wait = wait_q[match_idx];

  // Range and wait fields need no reset: the cleared enable flags keep them inert.
  always_ff @(posedge clk) begin
    if (cfg_we && cfg_idx_ok) begin
      start_q[cfg_idx] <= cfg_start;
      end_q[cfg_idx]   <= cfg_end;
      wait_q[cfg_idx]  <= cfg_wait;
    end
  end

  // Entry enable flags, cleared by reset so the table comes up empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      rd_en_q <= '0;
      wr_en_q <= '0;
    end else if (cfg_we && cfg_idx_ok) begin
      valid_q[cfg_idx] <= cfg_valid;
      rd_en_q[cfg_idx] <= cfg_rd_en;
      wr_en_q[cfg_idx] <= cfg_wr_en;
    end
  end

  // Present the table to the matcher in the shared entry format.
  always_comb begin
    for (int i = 0; i < NUM_REGIONS; i++) begin
      regions[i] = '{start_addr: REGION_ADDR_MAX_W'(start_q[i]),
                     end_addr:   REGION_ADDR_MAX_W'(end_q[i]),
                     wait_cyc:   REGION_WAIT_MAX_W'(wait_q[i]),
                     rd_en:      rd_en_q[i],
                     wr_en:      wr_en_q[i],
                     valid:      valid_q[i]};
    end
  end

  region_match #(
    .NUM_REGIONS (NUM_REGIONS),
    .IDX_W       (IDX_W)
  ) u_match (
    .regions (regions),
    .addr    (REGION_ADDR_MAX_W'(cpu_a)),
    .rw      (cpu_rw),
    .hit     (match_hit),
    .idx     (match_idx)
  );

  // Bus-cycle FSM; the decode result is latched in DECODE so later table
  // writes cannot disturb an access already in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cs       <= '0;
      hit_idx  <= '0;
      dtack_n  <= 1'b1;
      berr_n   <= 1'b1;
      unmapped <= 1'b0;
    end else begin
      unmapped <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!cpu_as_n) state <= ST_DECODE;
        end
        ST_DECODE: begin
          if (cpu_as_n) begin
            state <= ST_IDLE;
          end else if (match_hit) begin
            cs      <= {{(NUM_REGIONS-1){1'b0}}, 1'b1} << match_idx;
            hit_idx <= match_idx;
            cnt     <= CNT_W'(match_wait);
            if ((match_wait == '0) && !ext_wait) begin
              dtack_n <= 1'b0;
              state   <= ST_ACK;
            end else begin
              state <= ST_WAIT;
            end
          end else begin
            cs       <= '0;
            unmapped <= 1'b1;
            cnt      <= CNT_W'(TIMEOUT - 1);
            state    <= ST_MISS;
          end
        end
        ST_WAIT: begin
          if (cpu_as_n) begin
            cs    <= '0;
            state <= ST_IDLE;
          end else begin
            if (cnt != '0) cnt <= cnt - 1'b1;
            // Acknowledge on the edge the count runs out, unless held off.
            if ((cnt <= CNT_W'(1)) && !ext_wait) begin
              dtack_n <= 1'b0;
              state   <= ST_ACK;
            end
          end
        end
        ST_ACK: begin
          if (cpu_as_n) begin
            dtack_n <= 1'b1;
            cs      <= '0;
            state   <= ST_IDLE;
          end
        end
        ST_MISS: begin
          if (cpu_as_n) begin
            state <= ST_IDLE;
          end else if (cnt == '0) begin
            berr_n <= 1'b0;
            state  <= ST_BERR;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_BERR: begin
          if (cpu_as_n) begin
            berr_n <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
